// File: rtl/alu_pkg.sv
// alu_pkg -- shared types for the alu_pipe block.
//   alu_op_t    : 3-bit operation select (ADD..MUL)
//   alu_state_t : control FSM states (IDLE/BUSY/DONE)
//   op_is_mul() : helper used by the top to route MUL to the iterative path
package alu_pkg;

  localparam int ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_state_t;

  function automatic logic op_is_mul(input alu_op_t op);
    return op == OP_MUL;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- unsigned shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load operands (bit 0 is folded in on this same edge)
//   a, b          : WIDTH-bit unsigned operands, sampled on start
//   done          : one-cycle pulse; prod is final while it is high
//   prod          : full 2*WIDTH-bit product, held until the next start
// Bit 0 is processed on the start edge and bits 1..WIDTH-1 on the following
// WIDTH-1 edges, so done is seen WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{WIDTH{1'b0}}, a} << 1;
      r_mplier <= b >> 1;
      r_acc    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
      r_cnt    <= CW'(1);
      r_busy   <= 1'b1;
      r_done   <= 1'b0;
    end else if (r_busy) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (r_cnt == CW'(WIDTH - 1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign done = r_done;
  assign prod = r_acc;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe -- single-issue ALU with valid/ready handshake on both sides.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : request handshake (op, a, b sampled on accept)
//   op                    : alu_op_t operation select
//   a, b                  : WIDTH-bit operands
//   out_valid / out_ready : result handshake
//   result, carry, zero, err : registered result and status, held under
//                              backpressure
// Build option: define ALU_PIPE_MUL_EN to include the iterative multiplier.
// Without it MUL completes in one cycle with result 0, zero 1, err 1 and the
// BUSY state is never entered.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);

`ifdef ALU_PIPE_MUL_EN
  localparam bit HAS_MUL = 1'b1;
`else
  localparam bit HAS_MUL = 1'b0;
`endif

  alu_state_t         r_state;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_zero;
  logic               r_err;

  logic               w_accept;
  logic               w_launch_mul;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_carry;
  logic               w_err;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  // A new request can enter while the current result leaves, which is what
  // gives one-per-cycle throughput for single-cycle ops.
  assign in_ready     = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_launch_mul = w_accept && op_is_mul(op) && HAS_MUL;

  assign w_sum = {1'b0, a} + {1'b0, b};

  // Single-cycle datapath; MUL here only covers the multiplier-less build.
  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_err   = 1'b0;
    case (op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = a - b;
        w_carry = (a < b);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_SLL: w_res = a << b[SHW-1:0];
      OP_SRL: w_res = a >> b[SHW-1:0];
      OP_MUL: w_err = !HAS_MUL;
      default: w_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_launch_mul),
    .a     (a),
    .b     (b),
    .done  (w_mul_done),
    .prod  (w_prod)
  );
`else
  assign w_mul_done = 1'b0;
  assign w_prod     = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_launch_mul) begin
      r_state <= BUSY;
    end else if (w_accept) begin
      r_state  <= DONE;
      r_result <= w_res;
      r_carry  <= w_carry;
      r_zero   <= (w_res == '0);
      r_err    <= w_err;
    end else if (r_state == BUSY) begin
      if (w_mul_done) begin
        r_state  <= DONE;
        r_result <= w_prod[WIDTH-1:0];
        r_carry  <= |w_prod[2*WIDTH-1:WIDTH];
        r_zero   <= (w_prod[WIDTH-1:0] == '0);
        r_err    <= 1'b0;
      end
    end else if ((r_state == DONE) && out_ready) begin
      r_state <= IDLE;
    end
  end

  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  alu_op_t      op = OP_ADD;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry, zero, err;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: returns {err, zero, carry, result} from plain integer maths.
  function automatic logic [W+2:0] model(input alu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    int ux = x;
    int uy = y;
    int r = 0;
    int p;
    logic c = 1'b0;
    logic e = 1'b0;
    case (o)
      OP_ADD: begin r = (ux + uy) % 256; c = (ux + uy) > 255; end
      OP_SUB: begin r = (ux - uy + 256) % 256; c = ux < uy; end
      OP_AND: r = ux & uy;
      OP_OR:  r = ux | uy;
      OP_XOR: r = ux ^ uy;
      OP_SLL: r = (ux * (1 << (uy % 8))) % 256;
      OP_SRL: r = ux / (1 << (uy % 8));
      default: begin
        p = ux * uy;
`ifdef ALU_PIPE_MUL_EN
        r = p % 256;
        c = p >= 256;
`else
        r = 0;
        e = (p >= 0);
`endif
      end
    endcase
    return {e, r == 0, c, r[W-1:0]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({out_valid, result, carry, zero, err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {out_valid, result, carry, zero, err});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  // One request from IDLE with out_ready high; checks latency and payload.
  task automatic do_single(input string name, input alu_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+2:0] exp_v = model(o, x, y);
    int exp_lat = 1;
    int cyc;
`ifdef ALU_PIPE_MUL_EN
    if (o == OP_MUL) exp_lat = W + 1;
`endif
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_idle_ready: got %b want 1", name, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_busy_ready: got %b want 0 at cycle %0d", name, in_ready, cyc); end
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (cyc !== exp_lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, exp_lat); end
    total++;
    if ({err, zero, carry, result} !== exp_v) begin
      bad++; $display("FAIL %s_value: got e/z/c/r=%h want %h (a=%h b=%h)", name, {err, zero, carry, result}, exp_v, x, y);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain: got out_valid=%b want 0", name, out_valid); end
  endtask

  task automatic test_scenarios();
    do_single("add_ff_01", OP_ADD, 8'hFF, 8'h01);
    do_single("sub_5_7",   OP_SUB, 8'h05, 8'h07);
    do_single("sll_81_09", OP_SLL, 8'h81, 8'h09);
    do_single("srl_80_07", OP_SRL, 8'h80, 8'h07);
    do_single("and_zero",  OP_AND, 8'hF0, 8'h0F);
  endtask

  task automatic test_mul();
    do_single("mul_10_11", OP_MUL, 8'h10, 8'h11);
    do_single("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF);
    do_single("mul_zero",  OP_MUL, 8'h00, 8'h5A);
  endtask

  task automatic test_random_single();
    for (int i = 0; i < 30; i++)
      do_single("rand", alu_op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom));
  endtask

  // Streams single-cycle ops; mode 0: 3 back-to-back ADDs with 3 stalled
  // cycles; mode 1: random valid/ready.
  task automatic run_stream(input string name, input int n, input int mode);
    logic [W+2:0] q[$];
    int idx = 0;
    int cyc = 0;
    int acc = 0;
    int dlv = 0;
    while ((idx < n || q.size() != 0) && cyc < 600) begin
      if (mode == 0) begin
        in_valid  = (idx < n);
        op        = OP_ADD;
        out_ready = (cyc >= 4);
      end else begin
        in_valid  = (idx < n) && ($urandom_range(0, 3) != 0);
        op        = alu_op_t'($urandom_range(0, 6));
        out_ready = ($urandom_range(0, 4) > 1) || (cyc > 500);
      end
      a = W'($urandom); b = W'($urandom);
      #1;
      total++;
      if (out_valid !== (q.size() != 0)) begin
        bad++; $display("FAIL %s_out_valid: got %b want %b at cycle %0d", name, out_valid, q.size() != 0, cyc);
      end
      if (out_valid && q.size() != 0) begin
        total++;
        if ({err, zero, carry, result} !== q[0]) begin
          bad++; $display("FAIL %s_value: got %h want %h at cycle %0d", name, {err, zero, carry, result}, q[0], cyc);
        end
      end
      total++;
      if (in_ready !== ((q.size() == 0) || out_ready)) begin
        bad++; $display("FAIL %s_in_ready: got %b want %b at cycle %0d", name, in_ready, (q.size() == 0) || out_ready, cyc);
      end
      if (out_valid && out_ready && q.size() != 0) begin void'(q.pop_front()); dlv++; end
      if (in_valid && in_ready) begin q.push_back(model(op, a, b)); idx++; acc++; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (cyc >= 600) begin bad++; $display("FAIL %s_timeout: got %0d cycles want <600", name, cyc); end
    total++;
    if (dlv !== n) begin bad++; $display("FAIL %s_count: got %0d delivered want %0d", name, dlv, n); end
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 3, 0);
  endtask

  task automatic test_random_stream();
    run_stream("stream", 60, 1);
  endtask

  // Reset 4 cycles into a MUL, with a competing handshake on the reset edge.
  task automatic test_reset_mid_mul();
    in_valid = 1'b1; op = OP_MUL; a = 8'h37; b = 8'hC5; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h02; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if ({out_valid, result, carry, zero, err} !== '0) begin
      bad++; $display("FAIL rst_mul_outputs: got %h want 0", {out_valid, result, carry, zero, err});
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mul_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mul_ghost: got out_valid=1 want 0 at cycle %0d", i); end
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_mul();
    test_random_single();
    test_back_to_back();
    test_random_stream();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
